fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction (range 1..4).
REQ-003 SHALL have parameter FWD_DEPTH, default 2, meaning forwarding stages after EX (EX/MEM = 1, MEM/WB = 2, ...; range 1..4).
REQ-004 SHALL have parameter LOAD_LAT, default 1, meaning stages a load needs before its data can be forwarded (range 0..FWD_DEPTH-1).
REQ-005 SHALL define local SEL_W = clog2(FWD_DEPTH+1).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 dec_valid  in  1  ID stage holds a valid instruction.
REQ-010 dec_src  in  NUM_SRC*REG_AW  source register numbers; source i is at bits [i*REG_AW +: REG_AW].
REQ-011 dec_src_use  in  NUM_SRC  per-source "operand actually read" mask.
REQ-012 dec_rd, dec_wr_en, dec_is_load  in  REG_AW/1/1  ID instruction's destination, register-write flag and load flag.
REQ-013 pipe_hold  in  1  global pipeline freeze (e.g. memory busy).
REQ-014 flush  in  1  kill the ID instruction and the EX instruction (taken branch).
REQ-015 fwd_sel  out  NUM_SRC*SEL_W  registered ALU-input mux select per source for the EX instruction: 0 = register file, k = stage k.
REQ-016 stall_id  out  1  combinational load-use stall of PC and IF/ID.
REQ-017 bubble_ex  out  1  registered; the EX slot holds a bubble.
REQ-018 stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-019 SHALL keep an internal tag pipeline of FWD_DEPTH+1 entries (stage 0 = EX, stage k = k-th stage after EX); each entry holds {valid, rd, wr_en, is_load}.
REQ-020 A stage matches source i when: entry valid; wr_en=1; rd != 0; rd == src_i; dec_src_use[i]=1.
REQ-021 The forwarding candidate for source i SHALL be the youngest matching stage among 0..FWD_DEPTH-1. The select value is candidate index + 1. With no match the value is 0.
REQ-022 Register 0 SHALL never be forwarded and never cause a stall.
REQ-023 stall_id SHALL be 1 when all of these hold: dec_valid=1; some source's youngest match is a stage j < LOAD_LAT; that stage has is_load=1; flush=0.
REQ-024 A match in an older stage SHALL NOT produce a stall or a forward when a younger non-load match exists.
REQ-025 On a clock edge with pipe_hold=0, stages 1..FWD_DEPTH SHALL shift from stages 0..FWD_DEPTH-1.
REQ-026 On that same edge, stage 0 SHALL load the ID instruction when dec_valid=1, stall_id=0 and flush=0. Otherwise stage 0 becomes a bubble (valid=0).
REQ-027 fwd_sel SHALL register the computed selects when the ID instruction enters stage 0. It SHALL be all zeros when a bubble enters.
REQ-028 bubble_ex SHALL equal the inverse of stage 0 valid.
REQ-029 With pipe_hold=1 and flush=0, all tags, fwd_sel, bubble_ex and stall_cnt SHALL hold. stall_id still reflects the current state.
REQ-030 With pipe_hold=1 and flush=1, stage 0 SHALL be invalidated, fwd_sel zeroed and bubble_ex set to 1. Stages 1..FWD_DEPTH SHALL hold.
REQ-031 stall_cnt SHALL increment on each edge where stall_id=1 and pipe_hold=0. It saturates at 16'hFFFF.
REQ-032 Latency: fwd_sel is valid in the cycle after the instruction leaves ID. stall_id has zero latency.

Reset
REQ-033 On rst=1 at an edge, all tag entries SHALL be cleared: valid=0, rd=0, wr_en=0, is_load=0.
REQ-034 On that edge, outputs SHALL become fwd_sel=0, bubble_ex=1 and stall_cnt=0. rst overrides pipe_hold and flush.
REQ-035 After reset, stall_id SHALL be 0 until a load is inserted.

Structure
REQ-036 A shared package fwd_pkg SHALL hold: the tag-entry struct, the SEL_W function (clog2), the constant REG_ZERO = 0, and the select encoding FWD_RF = 0.
REQ-037 The per-source youngest-match priority logic SHALL be one sub-module, fwd_src_match, instantiated NUM_SRC times by generate.

Verification
REQ-038 ALU chain: add r3 then sub r5,r3,r3 back to back -> fwd_sel src0 = 1 and src1 = 1 the next cycle, stall_id = 0.
REQ-039 Load-use: lw r4 followed by add r6,r4,r1 (LOAD_LAT=1) -> stall_id = 1 for exactly one cycle, bubble_ex = 1 and stall_cnt = 1. Then fwd_sel src0 = 2.
REQ-040 Priority and r0: r2 written in stages 0 and 1, and src1 = r0 -> src0 select = 1, src1 select = 0, and r0 is never stalled even after lw r0.
REQ-041 Hold/flush: pipe_hold=1 for 3 cycles during a load-use stall -> state frozen and stall_cnt unchanged. Then flush with hold -> bubble_ex = 1 and fwd_sel = 0.
REQ-042 Parameter sweep: FWD_DEPTH = 3, LOAD_LAT = 2, with lw r7 then two independent instructions then use of r7 -> no stall and select = 3. The same sweep with the use one instruction earlier -> one stall cycle.
REQ-043 Reset mid-stall -> all tags cleared, stall_id = 0, stall_cnt = 0 and bubble_ex = 1 on the next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_pkg;

  // Widest register address a tag entry can carry; narrower REG_AW values are
  // zero-extended into the rd field so one struct serves every instance.
  localparam int TAG_RD_W = 8;

  // Register 0 is hard-wired to zero and must never forward or stall.
  localparam int REG_ZERO = 0;

  // Select encoding: 0 picks the register file, k picks forwarding stage k.
  localparam int FWD_RF = 0;

  // One entry of the in-flight tag pipeline.
  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                wr_en;
    logic                is_load;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Ceiling log2, never below 1 so a select field always has at least one bit.
  function automatic int fwd_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Youngest-match priority for one source operand against the forwarding
// candidates (stages 0..FWD_DEPTH-1). Produces the ALU mux select and a flag
// telling whether that youngest producer is a load still too young to forward.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = 2
) (
  input  logic [REG_AW-1:0]          src,
  input  logic                       src_use,
  input  logic [FWD_DEPTH*TAG_W-1:0] tags,
  output logic [SEL_W-1:0]           sel,
  output logic                       load_hazard
);

  tag_t cand;
  logic src_live;

  // An unused operand or a read of r0 can never depend on an in-flight write.
  assign src_live = src_use && (src != REG_AW'(REG_ZERO));

  // Walk oldest to youngest so the youngest match overwrites older ones; a
  // younger non-load producer therefore also cancels an older load hazard.
  always_comb begin
    sel         = SEL_W'(FWD_RF);
    load_hazard = 1'b0;
    cand        = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      cand = tag_t'(tags[k*TAG_W +: TAG_W]);
      if (src_live && cand.valid && cand.wr_en &&
          (cand.rd == TAG_RD_W'(src))) begin
        sel         = SEL_W'(k + 1);
        load_hazard = cand.is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit. Tracks the destination tags of
// instructions from EX onward, stalls ID while a needed load result is not yet
// forwardable, and registers per-source ALU mux selects for the EX slot.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int REG_AW    = 5,
  parameter  int NUM_SRC   = 2,
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_LAT  = 1,
  localparam int SEL_W     = fwd_clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic [NUM_SRC*REG_AW-1:0] dec_src,
  input  logic [NUM_SRC-1:0]        dec_src_use,
  input  logic [REG_AW-1:0]         dec_rd,
  input  logic                      dec_wr_en,
  input  logic                      dec_is_load,
  input  logic                      pipe_hold,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [15:0]               stall_cnt
);

  // Tag pipeline: index 0 is EX, index k is the k-th stage after EX.
  tag_t                       tag_p [0:FWD_DEPTH];
  logic [FWD_DEPTH*TAG_W-1:0] cand_flat;
  logic [NUM_SRC*SEL_W-1:0]   sel_next;
  logic [NUM_SRC-1:0]         hazard;
  tag_t                       id_tag;
  logic                       issue;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Flatten the forwarding candidates for the per-source matchers; the last
  // stage is only tracked, never forwarded from.
  always_comb begin
    cand_flat = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      cand_flat[k*TAG_W +: TAG_W] = tag_p[k];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(
      .REG_AW   (REG_AW),
      .FWD_DEPTH(FWD_DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_match (
      .src        (dec_src[g*REG_AW +: REG_AW]),
      .src_use    (dec_src_use[g]),
      .tags       (cand_flat),
      .sel        (sel_next[g*SEL_W +: SEL_W]),
      .load_hazard(hazard[g])
    );
  end

  // A flushed ID instruction is dead, so it cannot hold the front end.
  assign stall_id = dec_valid && (|hazard) && !flush;
  assign issue    = dec_valid && !stall_id && !flush;

  // Tag describing the ID instruction should it advance into EX.
  always_comb begin
    id_tag         = '0;
    id_tag.valid   = 1'b1;
    id_tag.rd      = TAG_RD_W'(dec_rd);
    id_tag.wr_en   = dec_wr_en;
    id_tag.is_load = dec_is_load;
  end

  // ---- ID -> EX and EX -> later stages: tag pipeline advance ----
  // Advance the tag pipeline; a hold freezes it except that a flush still
  // kills the EX entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        tag_p[k] <= '0;
      end
    end else if (!pipe_hold) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        tag_p[k] <= tag_p[k-1];
      end
      if (issue) begin
        tag_p[0] <= id_tag;
      end else begin
        tag_p[0] <= '0;
      end
    end else if (flush) begin
      tag_p[0] <= '0;
    end
  end

  // ---- ID -> EX: registered ALU mux selects ----
  // Selects follow the instruction into EX; any bubble carries register-file
  // selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel <= '0;
    end else if (!pipe_hold) begin
      fwd_sel <= issue ? sel_next : '0;
    end else if (flush) begin
      fwd_sel <= '0;
    end
  end

  // Count cycles lost to load-use stalls; held cycles are not charged.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pipe_hold && stall_id) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign bubble_ex = !tag_p[0].valid;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (default 2/1 and depth 3, load
// latency 2) share stimulus; a stage-list model predicts every output each
// cycle, and directed sequences pin known results with literal values.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [9:0] dec_src;
  logic [1:0] dec_src_use;
  logic [4:0] dec_rd;
  logic       dec_wr_en;
  logic       dec_is_load;
  logic       pipe_hold;
  logic       flush;

  logic [3:0]  fwd_sel_a, fwd_sel_b;
  logic        stall_id_a, stall_id_b;
  logic        bubble_ex_a, bubble_ex_b;
  logic [15:0] stall_cnt_a, stall_cnt_b;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_use(dec_src_use), .dec_rd(dec_rd), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .pipe_hold(pipe_hold), .flush(flush),
    .fwd_sel(fwd_sel_a), .stall_id(stall_id_a), .bubble_ex(bubble_ex_a),
    .stall_cnt(stall_cnt_a)
  );

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2)) dut3 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_use(dec_src_use), .dec_rd(dec_rd), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .pipe_hold(pipe_hold), .flush(flush),
    .fwd_sel(fwd_sel_b), .stall_id(stall_id_b), .bubble_ex(bubble_ex_b),
    .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per configuration c, the in-flight instructions by stage position.
  bit mv [2][5];
  int mrd[2][5];
  bit mw [2][5];
  bit ml [2][5];
  int msel[2][2];
  int mcnt[2];

  function automatic int depth_of(int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int lat_of(int c);
    return (c == 0) ? 1 : 2;
  endfunction

  // Nearest in-flight producer of source i, or -1 when it reads the regfile.
  function automatic int youngest(int c, int i);
    int s;
    s = int'(dec_src[i*5 +: 5]);
    if (!dec_src_use[i] || s == 0) return -1;
    for (int k = 0; k < depth_of(c); k++) begin
      if (mv[c][k] && mw[c][k] && mrd[c][k] == s) return k;
    end
    return -1;
  endfunction

  function automatic bit exp_stall(int c);
    bit st;
    int y;
    st = 1'b0;
    for (int i = 0; i < 2; i++) begin
      y = youngest(c, i);
      if (y >= 0 && y < lat_of(c) && ml[c][y]) st = 1'b1;
    end
    return st && dec_valid && !flush;
  endfunction

  function automatic logic [3:0] exp_sel(int c);
    return 4'(msel[c][1] * 4 + msel[c][0]);
  endfunction

  task automatic upd(int c);
    bit st;
    int y0, y1;
    if (rst) begin
      for (int k = 0; k < 5; k++) begin
        mv[c][k] = 0; mrd[c][k] = 0; mw[c][k] = 0; ml[c][k] = 0;
      end
      msel[c][0] = 0; msel[c][1] = 0; mcnt[c] = 0;
    end else if (!pipe_hold) begin
      st = exp_stall(c);
      y0 = youngest(c, 0);
      y1 = youngest(c, 1);
      if (st && mcnt[c] < 65535) mcnt[c]++;
      for (int k = depth_of(c); k >= 1; k--) begin
        mv[c][k] = mv[c][k-1]; mrd[c][k] = mrd[c][k-1];
        mw[c][k] = mw[c][k-1]; ml[c][k] = ml[c][k-1];
      end
      if (dec_valid && !st && !flush) begin
        mv[c][0] = 1; mrd[c][0] = int'(dec_rd);
        mw[c][0] = dec_wr_en; ml[c][0] = dec_is_load;
        msel[c][0] = y0 + 1; msel[c][1] = y1 + 1;
      end else begin
        mv[c][0] = 0; mrd[c][0] = 0; mw[c][0] = 0; ml[c][0] = 0;
        msel[c][0] = 0; msel[c][1] = 0;
      end
    end else if (flush) begin
      mv[c][0] = 0;
      msel[c][0] = 0; msel[c][1] = 0;
    end
  endtask

  always @(posedge clk) begin
    upd(0);
    upd(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a_stall_id",  32'(stall_id_a),  32'(exp_stall(0)));
    chk("a_fwd_sel",   32'(fwd_sel_a),   32'(exp_sel(0)));
    chk("a_bubble_ex", 32'(bubble_ex_a), 32'(!mv[0][0]));
    chk("a_stall_cnt", 32'(stall_cnt_a), 32'(mcnt[0]));
    chk("b_stall_id",  32'(stall_id_b),  32'(exp_stall(1)));
    chk("b_fwd_sel",   32'(fwd_sel_b),   32'(exp_sel(1)));
    chk("b_bubble_ex", 32'(bubble_ex_b), 32'(!mv[1][0]));
    chk("b_stall_cnt", 32'(stall_cnt_b), 32'(mcnt[1]));
  end

  task automatic drv(input bit v, input int s0, input int s1, input bit [1:0] u,
                     input int rd, input bit wr, input bit ld);
    dec_valid   = v;
    dec_src     = {5'(s1), 5'(s0)};
    dec_src_use = u;
    dec_rd      = 5'(rd);
    dec_wr_en   = wr;
    dec_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; pipe_hold = 1'b0; flush = 1'b0;
    drv(0, 0, 0, 2'b00, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_bubble_a", 32'(bubble_ex_a), 1);
    chk("rst_bubble_b", 32'(bubble_ex_b), 1);
    chk("rst_fwd_sel",  32'(fwd_sel_a), 0);
    chk("rst_cnt",      32'(stall_cnt_a), 0);
    chk("rst_stall",    32'(stall_id_a), 0);

    // add r3,r1,r2 ; sub r5,r3,r3
    drv(1, 1, 2, 2'b11, 3, 1, 0); tick();
    drv(1, 3, 3, 2'b11, 5, 1, 0); #1;
    chk("alu_stall", 32'(stall_id_a), 0);
    tick(); #1;
    chk("alu_sel_a", 32'(fwd_sel_a), 32'h5);
    chk("alu_sel_b", 32'(fwd_sel_b), 32'h5);

    // lw r4,(r1) ; add r6,r4,r1
    drv(1, 1, 0, 2'b01, 4, 1, 1); tick();
    drv(1, 4, 1, 2'b11, 6, 1, 0); #1;
    chk("lu_stall1", 32'(stall_id_a), 1);
    tick(); #1;
    chk("lu_stall2", 32'(stall_id_a), 0);
    chk("lu_bubble", 32'(bubble_ex_a), 1);
    chk("lu_cnt",    32'(stall_cnt_a), 1);
    tick(); #1;
    chk("lu_sel", 32'(fwd_sel_a), 32'h2);

    // addi r9,r1 ; lw r4,(r9) ; add r6,r4,r1 under hold, then flush with hold
    drv(1, 1, 0, 2'b01, 9, 1, 0); tick();
    drv(1, 9, 0, 2'b01, 4, 1, 1); tick();
    drv(1, 4, 1, 2'b11, 6, 1, 0);
    pipe_hold = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("hold_stall",  32'(stall_id_a), 1);
      chk("hold_sel",    32'(fwd_sel_a), 32'h1);
      chk("hold_bubble", 32'(bubble_ex_a), 0);
      chk("hold_cnt",    32'(stall_cnt_a), 1);
      if (n < 3) tick();
    end
    flush = 1'b1; #1;
    chk("hf_stall", 32'(stall_id_a), 0);
    tick(); #1;
    chk("hf_bubble", 32'(bubble_ex_a), 1);
    chk("hf_sel",    32'(fwd_sel_a), 0);
    chk("hf_cnt",    32'(stall_cnt_a), 1);
    pipe_hold = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    tick();

    // lw r2 ; add r2 ; use r2 and r0 ; lw r0 ; use r0
    drv(1, 1, 0, 2'b01, 2, 1, 1); tick();
    drv(1, 1, 0, 2'b01, 2, 1, 0); tick();
    drv(1, 2, 0, 2'b11, 8, 1, 0); #1;
    chk("pr_stall", 32'(stall_id_a), 0);
    tick(); #1;
    chk("pr_sel", 32'(fwd_sel_a), 32'h1);
    drv(1, 1, 0, 2'b01, 0, 1, 1); tick();
    drv(1, 0, 0, 2'b11, 8, 1, 0); #1;
    chk("r0_stall", 32'(stall_id_a), 0);
    tick(); #1;
    chk("r0_sel", 32'(fwd_sel_a), 0);

    // depth 3 / latency 2: lw r7, two independents, use r7
    dec_valid = 1'b0; repeat (4) tick();
    drv(1, 1, 0, 2'b01, 7, 1, 1);  tick();
    drv(1, 1, 0, 2'b01, 10, 1, 0); tick();
    drv(1, 1, 0, 2'b01, 11, 1, 0); tick();
    drv(1, 7, 0, 2'b01, 12, 1, 0); #1;
    chk("sw_stall", 32'(stall_id_b), 0);
    tick(); #1;
    chk("sw_sel", 32'(fwd_sel_b), 32'h3);

    // same with the use one instruction earlier
    dec_valid = 1'b0; repeat (4) tick();
    drv(1, 1, 0, 2'b01, 7, 1, 1);  tick();
    drv(1, 1, 0, 2'b01, 10, 1, 0); tick();
    drv(1, 7, 0, 2'b01, 12, 1, 0); #1;
    chk("sw2_stall1", 32'(stall_id_b), 1);
    tick(); #1;
    chk("sw2_stall2", 32'(stall_id_b), 0);
    chk("sw2_bubble", 32'(bubble_ex_b), 1);
    tick(); #1;
    chk("sw2_sel", 32'(fwd_sel_b), 32'h3);

    // reset while a load-use stall is active
    dec_valid = 1'b0; repeat (4) tick();
    drv(1, 1, 0, 2'b01, 4, 1, 1); tick();
    drv(1, 4, 1, 2'b11, 6, 1, 0); #1;
    chk("rm_stall1", 32'(stall_id_a), 1);
    rst = 1'b1;
    tick(); #1;
    chk("rm_stall0", 32'(stall_id_a), 0);
    chk("rm_cnt",    32'(stall_cnt_a), 0);
    chk("rm_bubble", 32'(bubble_ex_a), 1);
    chk("rm_sel",    32'(fwd_sel_a), 0);
    rst = 1'b0;
    tick();

    // randomized traffic over a small register set to provoke hazards
    repeat (3000) begin
      drv($urandom_range(0, 9) != 0,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 3);
      pipe_hold = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; pipe_hold = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
